// File: rtl/layer_norm_arbiter_if.sv
// ---------------------------------------------------------------------------
// layer_norm_arbiter_if
// Bundles every non-clock/reset signal of layer_norm_arbiter.
//   Requester side : req, req_x, req_gamma, req_beta (in to arbiter)
//                    gnt, rsp_done, rsp_err, rsp_data, busy (out of arbiter)
//   Engine side    : ln_start, ln_x_in, ln_gamma, ln_beta (out of arbiter)
//                    ln_done, ln_x_out (in to arbiter)
// Modports:
//   slave  - the arbiter itself
//   master - its environment (requesters plus the shared layer_norm engine)
// ---------------------------------------------------------------------------
interface layer_norm_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 16,
  parameter int SEQ_LEN    = 8,
  parameter int EMB_DIM    = 8
);
  localparam int TW = DATA_WIDTH * SEQ_LEN * EMB_DIM;
  localparam int PW = DATA_WIDTH * EMB_DIM;

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*TW-1:0] req_x;
  logic [NUM_REQ*PW-1:0] req_gamma;
  logic [NUM_REQ*PW-1:0] req_beta;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rsp_done;
  logic [NUM_REQ-1:0]    rsp_err;
  logic [TW-1:0]         rsp_data;
  logic                  busy;
  logic                  ln_start;
  logic [TW-1:0]         ln_x_in;
  logic [PW-1:0]         ln_gamma;
  logic [PW-1:0]         ln_beta;
  logic                  ln_done;
  logic [TW-1:0]         ln_x_out;

  modport slave (
    input  req, req_x, req_gamma, req_beta, ln_done, ln_x_out,
    output gnt, rsp_done, rsp_err, rsp_data, busy,
           ln_start, ln_x_in, ln_gamma, ln_beta
  );

  modport master (
    output req, req_x, req_gamma, req_beta, ln_done, ln_x_out,
    input  gnt, rsp_done, rsp_err, rsp_data, busy,
           ln_start, ln_x_in, ln_gamma, ln_beta
  );
endinterface

// File: rtl/layer_norm_arbiter.sv
// ---------------------------------------------------------------------------
// layer_norm_arbiter
// Shares one layer_norm engine between NUM_REQ requesters. Pending requests
// are granted round-robin; the winner's tensor/gamma/beta are steered onto
// the engine, a one-cycle start is issued, and on engine done the result is
// captured in rsp_data and a one-cycle rsp_done goes to the winner.
//
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-high reset (the engine must share it)
//   bus  - layer_norm_arbiter_if.slave: requester bus and engine bus
//
// Optional feature: define LN_ARB_TIMEOUT_EN to build a WAIT watchdog of
// TIMEOUT_CYCLES cycles that completes a stuck job with rsp_done + rsp_err.
// Without it, rsp_err is tied low and WAIT persists until ln_done.
// ---------------------------------------------------------------------------
module layer_norm_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = 16,
  parameter int SEQ_LEN        = 8,
  parameter int EMB_DIM        = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  layer_norm_arbiter_if.slave  bus
);
  localparam int TW = DATA_WIDTH * SEQ_LEN * EMB_DIM;
  localparam int PW = DATA_WIDTH * EMB_DIM;
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t             state_r;
  logic [NUM_REQ-1:0] gnt_r;
  logic [NUM_REQ-1:0] rsp_done_r;
  logic [TW-1:0]      rsp_data_r;
  logic               busy_r;
  logic               ln_start_r;
  logic [IW-1:0]      rr_ptr_r;
  logic [IW-1:0]      gidx_r;

  logic [IW-1:0]      pick_s;
  logic               pick_valid_s;
  logic [IW-1:0]      cand_s;
  logic [IW-1:0]      next_ptr_s;
  logic [IW-1:0]      sel_s;

`ifdef LN_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [NUM_REQ-1:0] rsp_err_r;
  logic [CW-1:0]      wd_cnt_r;
`endif

  // Round-robin pick: scan offsets from the top down so the last hit, i.e.
  // the lowest offset from rr_ptr, is the one that sticks.
  always_comb begin
    pick_s       = rr_ptr_r;
    pick_valid_s = 1'b0;
    cand_s       = rr_ptr_r;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand_s = IW'((int'(rr_ptr_r) + i) % NUM_REQ);
      if (bus.req[cand_s]) begin
        pick_s       = cand_s;
        pick_valid_s = 1'b1;
      end else begin
        pick_valid_s = pick_valid_s;
      end
    end
  end

  // Pointer after the current job, wrapping at NUM_REQ.
  assign next_ptr_s = (gidx_r == IW'(NUM_REQ - 1)) ? {IW{1'b0}} : gidx_r + IW'(1);

  // Operand select: the granted slot while a job is in flight, otherwise the
  // slot the next round-robin search will start from. Both are registered,
  // so the operands cannot glitch while the engine holds them.
  assign sel_s = (|gnt_r) ? gidx_r : rr_ptr_r;

  assign bus.ln_x_in  = bus.req_x    [int'(sel_s) * TW +: TW];
  assign bus.ln_gamma = bus.req_gamma[int'(sel_s) * PW +: PW];
  assign bus.ln_beta  = bus.req_beta [int'(sel_s) * PW +: PW];

  assign bus.gnt      = gnt_r;
  assign bus.rsp_done = rsp_done_r;
  assign bus.rsp_data = rsp_data_r;
  assign bus.busy     = busy_r;
  assign bus.ln_start = ln_start_r;
`ifdef LN_ARB_TIMEOUT_EN
  assign bus.rsp_err  = rsp_err_r;
`else
  assign bus.rsp_err  = {NUM_REQ{1'b0}};
`endif

  // Control FSM with registered grant, pulses, result and pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      gnt_r      <= {NUM_REQ{1'b0}};
      rsp_done_r <= {NUM_REQ{1'b0}};
      rsp_data_r <= {TW{1'b0}};
      busy_r     <= 1'b0;
      ln_start_r <= 1'b0;
      rr_ptr_r   <= {IW{1'b0}};
      gidx_r     <= {IW{1'b0}};
`ifdef LN_ARB_TIMEOUT_EN
      rsp_err_r  <= {NUM_REQ{1'b0}};
      wd_cnt_r   <= {CW{1'b0}};
`endif
    end else begin
      // Pulses default low every cycle.
      rsp_done_r <= {NUM_REQ{1'b0}};
      ln_start_r <= 1'b0;
`ifdef LN_ARB_TIMEOUT_EN
      rsp_err_r  <= {NUM_REQ{1'b0}};
`endif
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            gnt_r      <= NUM_REQ'(1) << pick_s;
            gidx_r     <= pick_s;
            ln_start_r <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= LAUNCH;
          end
        end
        LAUNCH: begin
`ifdef LN_ARB_TIMEOUT_EN
          wd_cnt_r <= {CW{1'b0}};
`endif
          state_r  <= WAIT;
        end
        WAIT: begin
          // A done on the expiry cycle is still a success.
          if (bus.ln_done) begin
            rsp_data_r <= bus.ln_x_out;
            rsp_done_r <= gnt_r;
            gnt_r      <= {NUM_REQ{1'b0}};
            rr_ptr_r   <= next_ptr_s;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
`ifdef LN_ARB_TIMEOUT_EN
          end else if (wd_cnt_r == CW'(TIMEOUT_CYCLES)) begin
            rsp_done_r <= gnt_r;
            rsp_err_r  <= gnt_r;
            gnt_r      <= {NUM_REQ{1'b0}};
            rr_ptr_r   <= next_ptr_s;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end else begin
            wd_cnt_r   <= wd_cnt_r + CW'(1);
`endif
          end
        end
        default: begin
          gnt_r   <= {NUM_REQ{1'b0}};
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule
